// File: rtl/posit_ctrl_pkg.sv
// Shared types and constants for posit stream control blocks.
// Holds the sequencer state encoding and the NaR pattern generator.
package posit_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int MAX_POSIT_WIDTH = 64;

    // NaR is a lone sign bit; callers truncate to their posit width.
    function automatic logic [MAX_POSIT_WIDTH-1:0] nar_word(input int width);
        nar_word = {{(MAX_POSIT_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

// File: rtl/relu_stream_sequencer_if.sv
// Command, input stream, output stream and status bundle of the ReLU sequencer.
// slave is the sequencer side, master the side that drives commands and data.
interface relu_stream_sequencer_if #(
    parameter int POSIT_WIDTH = 16,
    parameter int LEN_WIDTH   = 16
);
    logic                   start_i;
    logic [LEN_WIDTH-1:0]   len_i;
    logic                   relu_en_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [POSIT_WIDTH-1:0] posit_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [POSIT_WIDTH-1:0] posit_o;
    logic                   last_o;
    logic                   busy_o;
    logic                   done_o;
    logic [LEN_WIDTH-1:0]   zero_cnt_o;

    modport slave (
        input  start_i, len_i, relu_en_i, in_valid_i, posit_i, out_ready_i,
        output in_ready_o, out_valid_o, posit_o, last_o, busy_o, done_o, zero_cnt_o
    );

    modport master (
        output start_i, len_i, relu_en_i, in_valid_i, posit_i, out_ready_i,
        input  in_ready_o, out_valid_o, posit_o, last_o, busy_o, done_o, zero_cnt_o
    );
endinterface

// File: rtl/relu_stream_sequencer_relu.sv
// Combinational posit ReLU: negative words become zero, others pass; no latency.
// Pure function of its input, so it has no flow control of its own.
module relu_stream_sequencer_relu #(
    parameter int POSIT_WIDTH = 16
) (
    input  logic [POSIT_WIDTH-1:0] x,
    output logic [POSIT_WIDTH-1:0] y
);
    assign y = x[POSIT_WIDTH-1] ? '0 : x;
endmodule

// File: rtl/relu_stream_sequencer.sv
// Burst sequencer applying optional posit ReLU to a stream; one-cycle latency, one word per cycle.
// Input is stalled whenever the single output register is full and downstream is not ready.
module relu_stream_sequencer
    import posit_ctrl_pkg::*;
#(
    parameter int POSIT_WIDTH   = 16,
    parameter int LEN_WIDTH     = 16,
    parameter bit NAR_PROPAGATE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    relu_stream_sequencer_if.slave bus
);
    localparam logic [POSIT_WIDTH-1:0] NAR = POSIT_WIDTH'(nar_word(POSIT_WIDTH));

    seq_state_t             state, next_state;
    logic [LEN_WIDTH-1:0]   remaining, zero_cnt;
    logic                   relu_en, out_valid, last_q, done_q;
    logic [POSIT_WIDTH-1:0] posit_q, relu_y, xform;
    logic                   in_ready, in_xfer, out_xfer, start_ok, start_zero, is_final;

    assign start_ok   = (state == IDLE) && bus.start_i && (bus.len_i != '0);
    assign start_zero = (state == IDLE) && bus.start_i && (bus.len_i == '0);
    assign in_ready   = (state == RUN) && (!out_valid || bus.out_ready_i);
    assign in_xfer    = bus.in_valid_i && in_ready;
    assign out_xfer   = out_valid && bus.out_ready_i;
    assign is_final   = (remaining == LEN_WIDTH'(1));

    relu_stream_sequencer_relu #(.POSIT_WIDTH(POSIT_WIDTH)) u_relu (
        .x (bus.posit_i),
        .y (relu_y)
    );

    always_comb begin
        xform = relu_y;
        if (!relu_en)
            xform = bus.posit_i;
        else if (NAR_PROPAGATE && (bus.posit_i == NAR))
            xform = bus.posit_i;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_ok) next_state = RUN;
            RUN:     if (in_xfer && is_final) next_state = DRAIN;
            DRAIN:   if (out_xfer) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            relu_en   <= 1'b0;
            zero_cnt  <= '0;
            out_valid <= 1'b0;
            posit_q   <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // In DRAIN the register can only hold the last word, so any output transfer ends the burst.
            done_q <= start_zero || ((state == DRAIN) && out_xfer);
            if (start_ok) begin
                remaining <= bus.len_i;
                relu_en   <= bus.relu_en_i;
            end else if (in_xfer) begin
                remaining <= remaining - LEN_WIDTH'(1);
            end
            if (start_ok || start_zero)
                zero_cnt <= '0;
            else if (in_xfer && (xform == '0) && (bus.posit_i != '0) && (zero_cnt != '1))
                zero_cnt <= zero_cnt + LEN_WIDTH'(1);
            if (in_xfer) begin
                out_valid <= 1'b1;
                posit_q   <= xform;
                last_q    <= is_final;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.posit_o     = posit_q;
    assign bus.last_o      = last_q;
    assign bus.busy_o      = (state != IDLE);
    assign bus.done_o      = done_q;
    assign bus.zero_cnt_o  = zero_cnt;
endmodule
